period_meter: RTL and testbench

- Measures a slow, asynchronous, clock-like input, such as a divided clock from another board or block.
- Reports its period and high time as counts of `clk` cycles, with a one-cycle valid strobe per completed period.
- Raises a sticky timeout flag when no rising edge arrives within a bounded window.
- Sits alongside the team's clock-divider blocks as their measuring counterpart, used for bring-up checks and self-test of divided clocks.

---
 rtl/period_meter_if.sv | 30 +++
 rtl/period_meter.sv | 131 +++++++++++++
 tb/tb_period_meter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/period_meter_if.sv
// Signal-under-test, enable and measurement results of one period_meter.
// master drives the input side and observes results; slave is the meter itself.
interface period_meter_if #(
    parameter int unsigned COUNT_WIDTH = 28
);
    logic                   sig_in;
    logic                   enable;
    logic [COUNT_WIDTH-1:0] period;
    logic [COUNT_WIDTH-1:0] high_time;
    logic                   period_valid;
    logic                   timeout;

    modport master (
        output sig_in,
        output enable,
        input  period,
        input  high_time,
        input  period_valid,
        input  timeout
    );

    modport slave (
        input  sig_in,
        input  enable,
        output period,
        output high_time,
        output period_valid,
        output timeout
    );
endinterface

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous clock-like input in clk cycles,
// with a one-cycle valid strobe per period and a sticky timeout on missing rising edges.
module period_meter #(
    parameter int unsigned COUNT_WIDTH = 28,
    parameter int unsigned MAX_PERIOD  = 200000000
) (
    input  logic          clk,
    input  logic          rst,
    period_meter_if.slave bus
);
    localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_PERIOD);
    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic                   sync_q, s, s_d;
    logic                   rise;
    logic [COUNT_WIDTH-1:0] cnt, cnt_nx;
    logic [COUNT_WIDTH-1:0] hcnt, hcnt_nx;
    logic [COUNT_WIDTH-1:0] period_q, period_nx;
    logic [COUNT_WIDTH-1:0] high_q, high_nx;
    logic                   valid_q, valid_nx;
    logic                   timeout_q, timeout_nx;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= bus.sig_in;
            s      <= sync_q;
            s_d    <= s;
        end
    end

    assign rise = s & ~s_d;

    // State and measurement registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hcnt      <= hcnt_nx;
            period_q  <= period_nx;
            high_q    <= high_nx;
            valid_q   <= valid_nx;
            timeout_q <= timeout_nx;
        end
    end

    // Next-state and next-output logic; rise takes priority over the timeout check.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        hcnt_nx    = hcnt;
        period_nx  = period_q;
        high_nx    = high_q;
        valid_nx   = 1'b0;
        timeout_nx = timeout_q;

        if (!bus.enable) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            hcnt_nx    = '0;
            timeout_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_nx   = '0;
                    hcnt_nx  = '0;
                    state_nx = ARM;
                end
                ARM: begin
                    if (rise) begin
                        state_nx = MEASURE;
                        cnt_nx   = ONE;
                        hcnt_nx  = ONE;
                    end else if (cnt == MAX_CNT) begin
                        timeout_nx = 1'b1;
                        cnt_nx     = '0;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_nx  = cnt;
                        high_nx    = hcnt;
                        valid_nx   = 1'b1;
                        timeout_nx = 1'b0;
                        cnt_nx     = ONE;
                        hcnt_nx    = ONE;
                    end else if (cnt == MAX_CNT) begin
                        timeout_nx = 1'b1;
                        state_nx   = ARM;
                        cnt_nx     = '0;
                        hcnt_nx    = '0;
                    end else begin
                        cnt_nx  = cnt + ONE;
                        hcnt_nx = hcnt + COUNT_WIDTH'(s);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    hcnt_nx  = '0;
                end
            endcase
        end
    end

    assign bus.period       = period_q;
    assign bus.high_time    = high_q;
    assign bus.period_valid = valid_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with COUNT_WIDTH=8, MAX_PERIOD=64.
// Inputs change 1 time unit after posedge; outputs are observed on the negedge.
module tb_period_meter;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    period_meter_if #(.COUNT_WIDTH(CW)) bus ();

    period_meter #(.COUNT_WIDTH(CW), .MAX_PERIOD(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clk cycle: drive sig_in for this cycle, then wait to the observation point.
    task automatic tick(input logic v);
        @(posedge clk);
        #1;
        bus.sig_in = v;
        @(negedge clk);
    endtask

    task automatic cleanup();
        bus.enable = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b0);
    endtask

    task automatic test_reset();
        logic [2*CW+1:0] got;
        bus.enable = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(logic'(((c / 2) % 2) == 0));
            got = {bus.period, bus.high_time, bus.period_valid, bus.timeout};
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("FAIL reset_hold c=%0d: got %h expected 0", c, got);
            end
        end
        bus.enable = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(1'b0);
            got = {bus.period, bus.high_time, bus.period_valid, bus.timeout};
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("FAIL reset_release c=%0d: got %h expected 0", c, got);
            end
        end
    endtask

    task automatic test_square();
        int n = 0;
        int last = 0;
        cleanup();
        bus.enable = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick(logic'((c % 10) < 5));
            vectors++;
            if (bus.timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL square_timeout c=%0d: got %b expected 0", c, bus.timeout);
            end
            if (bus.period_valid === 1'b1) begin
                n++;
                vectors++;
                if (bus.period !== 8'd10 || bus.high_time !== 8'd5) begin
                    miscompares++;
                    $display("FAIL square_value c=%0d: got %0d/%0d expected 10/5", c, bus.period, bus.high_time);
                end
                vectors++;
                if ((n == 1 && c != 13) || (n > 1 && c - last != 10)) begin
                    miscompares++;
                    $display("FAIL square_timing strobe %0d: got tick %0d (prev %0d) expected 13 then every 10", n, c, last);
                end
                last = c;
            end
        end
        vectors++;
        if (n != 7) begin
            miscompares++;
            $display("FAIL square_count: got %0d strobes expected 7", n);
        end
    endtask

    task automatic test_asym_switch();
        int  n = 0;
        logic v;
        cleanup();
        bus.enable = 1'b1;
        for (int c = 0; c < 232; c++) begin
            v = (c < 72) ? logic'((c % 12) < 3) : logic'(((c - 72) % 40) < 20);
            tick(v);
            if (bus.period_valid === 1'b1) begin
                n++;
                vectors++;
                if (n <= 6 && (bus.period !== 8'd12 || bus.high_time !== 8'd3)) begin
                    miscompares++;
                    $display("FAIL asym_value strobe %0d: got %0d/%0d expected 12/3", n, bus.period, bus.high_time);
                end else if (n > 6 && (bus.period !== 8'd40 || bus.high_time !== 8'd20)) begin
                    miscompares++;
                    $display("FAIL switch_value strobe %0d: got %0d/%0d expected 40/20", n, bus.period, bus.high_time);
                end
            end
        end
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("FAIL asym_count: got %0d strobes expected 9", n);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        cleanup();
        bus.enable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick(1'b0);
            if (bus.period_valid === 1'b1) n++;
            if (c == 64 || c == 65) begin
                vectors++;
                if (bus.timeout !== logic'(c == 65)) begin
                    miscompares++;
                    $display("FAIL arm_timeout c=%0d: got %b expected %b", c, bus.timeout, c == 65);
                end
            end
        end
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL arm_no_strobe: got %0d strobes expected 0", n);
        end
        for (int c = 0; c < 60; c++) begin
            tick(logic'((c % 20) < 10));
            vectors++;
            if (bus.period_valid === 1'b1) begin
                n++;
                if (bus.period !== 8'd20 || bus.high_time !== 8'd10 || bus.timeout !== 1'b0) begin
                    miscompares++;
                    $display("FAIL recover_value c=%0d: got %0d/%0d to=%b expected 20/10 to=0",
                             c, bus.period, bus.high_time, bus.timeout);
                end
            end else if (bus.timeout !== logic'(n == 0)) begin
                miscompares++;
                $display("FAIL recover_timeout c=%0d: got %b expected %b", c, bus.timeout, n == 0);
            end
        end
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL recover_count: got %0d strobes expected 2", n);
        end
    endtask

    task automatic test_boundary();
        int n = 0;
        cleanup();
        bus.enable = 1'b1;
        for (int c = 0; c < 192; c++) begin
            tick(logic'((c % 64) < 32));
            vectors++;
            if (bus.timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL max_timeout c=%0d: got %b expected 0", c, bus.timeout);
            end
            if (bus.period_valid === 1'b1) begin
                n++;
                vectors++;
                if (bus.period !== 8'd64 || bus.high_time !== 8'd32) begin
                    miscompares++;
                    $display("FAIL max_value c=%0d: got %0d/%0d expected 64/32", c, bus.period, bus.high_time);
                end
            end
        end
        vectors++;
        if (n != 2) begin
            miscompares++;
            $display("FAIL max_count: got %0d strobes expected 2", n);
        end
        n = 0;
        cleanup();
        bus.enable = 1'b1;
        for (int c = 0; c < 195; c++) begin
            tick(logic'((c % 65) < 32));
            if (bus.period_valid === 1'b1) n++;
            if (c == 66 || c == 67) begin
                vectors++;
                if (bus.timeout !== logic'(c == 67)) begin
                    miscompares++;
                    $display("FAIL over_timeout c=%0d: got %b expected %b", c, bus.timeout, c == 67);
                end
            end
        end
        vectors++;
        if (n != 0 || bus.timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL over_final: got %0d strobes to=%b expected 0 strobes to=1", n, bus.timeout);
        end
    endtask

    // use_rst=0 drops enable mid-measurement; use_rst=1 pulses reset instead.
    task automatic test_interrupt(input bit use_rst);
        int n = 0;
        int first_after = -1;
        logic [2*CW+1:0] got;
        cleanup();
        bus.enable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c == 45) begin
                if (use_rst) rst = 1'b1;
                else bus.enable = 1'b0;
            end
            if (c == 70) begin
                rst = 1'b0;
                bus.enable = 1'b1;
            end
            tick(logic'((c % 10) < 5));
            got = {bus.period, bus.high_time, bus.period_valid, bus.timeout};
            if (c >= 45 && c < 70) begin
                vectors++;
                if ((use_rst && got !== '0) || (!use_rst && got !== {8'd10, 8'd5, 2'b00})) begin
                    miscompares++;
                    $display("FAIL %s_hold c=%0d: got %h expected %h", use_rst ? "rst" : "en", c, got,
                             use_rst ? 18'h0 : {8'd10, 8'd5, 2'b00});
                end
            end
            if (bus.period_valid === 1'b1) begin
                n++;
                if (c >= 70 && first_after < 0) first_after = c;
                vectors++;
                if (bus.period !== 8'd10 || bus.high_time !== 8'd5) begin
                    miscompares++;
                    $display("FAIL %s_value c=%0d: got %0d/%0d expected 10/5", use_rst ? "rst" : "en",
                             c, bus.period, bus.high_time);
                end
            end
        end
        vectors++;
        if (n != 6 || first_after != 83) begin
            miscompares++;
            $display("FAIL %s_recover: got %0d strobes first at %0d expected 6 first at 83",
                     use_rst ? "rst" : "en", n, first_after);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.sig_in  = 1'b0;
        bus.enable  = 1'b0;
        test_reset();
        test_square();
        test_asym_switch();
        test_timeout();
        test_boundary();
        test_interrupt(1'b0);
        test_interrupt(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
